// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} arb_state_t;
  localparam int ETH_MAX_FRAME = 1518;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick, purely combinational.
// On a tie the source that was not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b10)      gnt_idx = 1'b1;
    else if (req == 2'b11) gnt_idx = ~last_grant;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-atomic round-robin arbiter sharing one FIFO write port between two byte sources.
// Zero-latency datapath; owner ready follows ~fifo_full, tails beyond MAX_LEN are drained.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = ETH_MAX_FRAME,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             s0_valid,
  input  logic [WIDTH-1:0] s0_data,
  input  logic             s0_last,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [WIDTH-1:0] s1_data,
  input  logic             s1_last,
  output logic             s1_ready,
  input  logic             fifo_full,
  output logic             fifo_w_en,
  output logic [WIDTH:0]   fifo_data,
  output logic             trunc_err,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam int BC_W = $clog2(MAX_LEN + 1);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(MAX_LEN - 1);

  arb_state_t       state, state_nxt;
  logic             owner, last_grant;
  logic [BC_W-1:0]  byte_cnt;
  logic             gnt_valid, gnt_idx;
  logic             owner_valid, owner_last, owner_rdy, accept, at_limit;
  logic [WIDTH-1:0] owner_data;

  rr_pick2 u_pick (
    .req        ({s1_valid, s0_valid}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign owner_valid = owner ? s1_valid : s0_valid;
  assign owner_last  = owner ? s1_last  : s0_last;
  assign owner_data  = owner ? s1_data  : s0_data;
  assign at_limit    = (byte_cnt == LAST_IDX);
  assign s0_ready    = owner_rdy & ~owner;
  assign s1_ready    = owner_rdy &  owner;

  always_comb begin
    state_nxt = state;
    owner_rdy = 1'b0;
    accept    = 1'b0;
    fifo_w_en = 1'b0;
    fifo_data = '0;
    case (state)
      IDLE: if (gnt_valid) state_nxt = XFER;
      XFER: begin
        owner_rdy = ~fifo_full;
        accept    = owner_valid & ~fifo_full;
        if (accept) begin
          fifo_w_en = 1'b1;
          fifo_data = {owner_last | at_limit, owner_data};
          if (owner_last)    state_nxt = IDLE;
          else if (at_limit) state_nxt = DRAIN;
        end
      end
      // Truncated tail: swallow bytes without writing until the source closes its frame.
      DRAIN: begin
        owner_rdy = 1'b1;
        accept    = owner_valid;
        if (accept && owner_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      byte_cnt   <= '0;
      frame_cnt  <= '0;
      trunc_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      trunc_err <= 1'b0;
      case (state)
        IDLE: if (gnt_valid) owner <= gnt_idx;
        XFER: if (accept) begin
          if (owner_last) begin
            byte_cnt   <= '0;
            frame_cnt  <= frame_cnt + 1'b1;
            last_grant <= owner;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
            if (at_limit) begin
              frame_cnt  <= frame_cnt + 1'b1;
              trunc_err  <= 1'b1;
              last_grant <= owner;
            end
          end
        end
        DRAIN: if (accept && owner_last) byte_cnt <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with MAX_LEN=4 and CNT_W=3.
module tb_fifo_wr_arbiter;
  localparam int W  = 8;
  localparam int ML = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
  logic [W-1:0]  s0_data = '0, s1_data = '0;
  logic          fifo_full = 1'b0;
  logic          s0_ready, s1_ready, fifo_w_en, trunc_err;
  logic [W:0]    fifo_data;
  logic [CW-1:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];
  logic [W:0] got_d [0:255];
  int         got_c [0:255];
  int         wr_cnt = 0, cyc_n = 0, trunc_cnt = 0, s1_rdy_cnt = 0, nz_cnt = 0;
  int         rd_ptr = 0;

  fifo_wr_arbiter #(.WIDTH(W), .MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk       (clk),
    .arst      (arst),
    .s0_valid  (s0_valid),
    .s0_data   (s0_data),
    .s0_last   (s0_last),
    .s0_ready  (s0_ready),
    .s1_valid  (s1_valid),
    .s1_data   (s1_data),
    .s1_last   (s1_last),
    .s1_ready  (s1_ready),
    .fifo_full (fifo_full),
    .fifo_w_en (fifo_w_en),
    .fifo_data (fifo_data),
    .trunc_err (trunc_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Output logger: records every FIFO write plus event counters, sampled mid-cycle.
  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (fifo_w_en === 1'b1) begin
      if (wr_cnt < 256) begin
        got_d[wr_cnt] <= fifo_data;
        got_c[wr_cnt] <= cyc_n;
      end
      wr_cnt <= wr_cnt + 1;
    end else if (fifo_data !== '0) begin
      nz_cnt <= nz_cnt + 1;
    end
    if (trunc_err === 1'b1) trunc_cnt <= trunc_cnt + 1;
    if (s1_ready === 1'b1) s1_rdy_cnt <= s1_rdy_cnt + 1;
  end

  task automatic set_src(input bit src, input logic v, input logic [W-1:0] d, input logic l);
    if (src) begin s1_valid = v; s1_data = d; s1_last = l; end
    else     begin s0_valid = v; s0_data = d; s0_last = l; end
  endtask

  task automatic wait_hs(input bit src);
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = ((src ? s1_ready : s0_ready) === 1'b1);
      n++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL handshake_timeout src=%0d actual=no_ready required=ready", src);
    end
    @(posedge clk); #1;
  endtask

  // Sends nfr frames of len bytes; stop_after>=0 abandons mid-frame leaving valid high.
  task automatic send(input bit src, input int nfr, input int len, input logic [W-1:0] base,
                      input int stop_after);
    int done = 0;
    for (int f = 0; f < nfr; f++)
      for (int i = 0; i < len; i++) begin
        if (done == stop_after) return;
        set_src(src, 1'b1, base + W'(f * len + i), (i == len - 1));
        wait_hs(src);
        done++;
      end
    set_src(src, 1'b0, '0, 1'b0);
  endtask

  task automatic push_frame(input logic [W-1:0] base, input int len, input int upto);
    logic e;
    for (int i = 0; i < len && i < ML && i < upto; i++) begin
      e = (i == len - 1) || (i == ML - 1);
      exp_q.push_back({e, base + W'(i)});
    end
  endtask

  task automatic do_reset();
    set_src(1'b0, 1'b0, '0, 1'b0);
    set_src(1'b1, 1'b0, '0, 1'b0);
    fifo_full = 1'b0;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); arst = 1'b0;
    @(posedge clk); #1;
    rd_ptr = wr_cnt;
    exp_q.delete();
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (s0_ready !== 1'b0)  begin bad++; $display("FAIL rst_s0_ready actual=%b required=0", s0_ready); end
    total++; if (s1_ready !== 1'b0)  begin bad++; $display("FAIL rst_s1_ready actual=%b required=0", s1_ready); end
    total++; if (fifo_w_en !== 1'b0) begin bad++; $display("FAIL rst_w_en actual=%b required=0", fifo_w_en); end
    total++; if (fifo_data !== '0)   begin bad++; $display("FAIL rst_data actual=%h required=0", fifo_data); end
    total++; if (trunc_err !== 1'b0) begin bad++; $display("FAIL rst_trunc actual=%b required=0", trunc_err); end
    total++; if (frame_cnt !== '0)   begin bad++; $display("FAIL rst_frame_cnt actual=%0d required=0", frame_cnt); end
  endtask

  task automatic test_single();
    int s1r, tr;
    logic [W:0] e;
    do_reset();
    s1r = s1_rdy_cnt; tr = trunc_cnt;
    push_frame(8'h10, 4, 99);
    send(1'b0, 1, 4, 8'h10, -1);
    repeat (2) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (rd_ptr >= wr_cnt) begin bad++; $display("FAIL single_missing actual=none required=%h", e); end
      else begin
        if (got_d[rd_ptr] !== e) begin bad++; $display("FAIL single_data actual=%h required=%h", got_d[rd_ptr], e); end
        rd_ptr++;
      end
    end
    total++; if (wr_cnt != rd_ptr) begin bad++; $display("FAIL single_extra actual=%0d required=%0d", wr_cnt, rd_ptr); end
    total++; if (frame_cnt !== 3'd1) begin bad++; $display("FAIL single_frame_cnt actual=%0d required=1", frame_cnt); end
    total++; if (s1_rdy_cnt != s1r) begin bad++; $display("FAIL single_s1_ready actual=%0d required=0", s1_rdy_cnt - s1r); end
    total++; if (trunc_cnt != tr) begin bad++; $display("FAIL single_trunc actual=%0d required=0", trunc_cnt - tr); end
  endtask

  task automatic test_tie();
    int b;
    logic [W:0] e;
    do_reset();
    b = rd_ptr;
    push_frame(8'h00, 3, 99);
    push_frame(8'h80, 3, 99);
    fork
      send(1'b0, 1, 3, 8'h00, -1);
      send(1'b1, 1, 3, 8'h80, -1);
    join
    total++; if (frame_cnt !== 3'd2) begin bad++; $display("FAIL tie_frame_cnt actual=%0d required=2", frame_cnt); end
    push_frame(8'h08, 1, 99);
    push_frame(8'h88, 1, 99);
    fork
      send(1'b0, 1, 1, 8'h08, -1);
      send(1'b1, 1, 1, 8'h88, -1);
    join
    repeat (2) @(posedge clk); #1;
    total++;
    if (wr_cnt < b + 4) begin bad++; $display("FAIL tie_gap actual=too_few_writes required=gap2"); end
    else if (got_c[b + 3] - got_c[b + 2] != 2) begin
      bad++; $display("FAIL tie_gap actual=%0d required=2", got_c[b + 3] - got_c[b + 2]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (rd_ptr >= wr_cnt) begin bad++; $display("FAIL tie_missing actual=none required=%h", e); end
      else begin
        if (got_d[rd_ptr] !== e) begin bad++; $display("FAIL tie_order actual=%h required=%h", got_d[rd_ptr], e); end
        rd_ptr++;
      end
    end
    total++; if (wr_cnt != rd_ptr) begin bad++; $display("FAIL tie_extra actual=%0d required=%0d", wr_cnt, rd_ptr); end
  endtask

  task automatic test_full();
    int n0;
    logic [W:0] e;
    do_reset();
    push_frame(8'h20, 4, 99);
    fork
      send(1'b0, 1, 4, 8'h20, -1);
      begin
        @(posedge clk); @(posedge clk); #1;
        fifo_full = 1'b1;
        n0 = wr_cnt;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          total++; if (s0_ready !== 1'b0) begin bad++; $display("FAIL full_ready cyc=%0d actual=%b required=0", k, s0_ready); end
          @(posedge clk); #1;
        end
        total++; if (wr_cnt != n0) begin bad++; $display("FAIL full_no_write actual=%0d required=0", wr_cnt - n0); end
        fifo_full = 1'b0;
        @(posedge clk); #1;
        total++; if (wr_cnt != n0 + 1) begin bad++; $display("FAIL full_resume actual=%0d required=1", wr_cnt - n0); end
      end
    join
    repeat (2) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (rd_ptr >= wr_cnt) begin bad++; $display("FAIL full_missing actual=none required=%h", e); end
      else begin
        if (got_d[rd_ptr] !== e) begin bad++; $display("FAIL full_data actual=%h required=%h", got_d[rd_ptr], e); end
        rd_ptr++;
      end
    end
    total++; if (wr_cnt != rd_ptr) begin bad++; $display("FAIL full_extra actual=%0d required=%0d", wr_cnt, rd_ptr); end
  endtask

  task automatic test_trunc();
    int tr;
    logic [W:0] e;
    do_reset();
    tr = trunc_cnt;
    push_frame(8'h90, 7, 99);
    send(1'b1, 1, 7, 8'h90, -1);
    repeat (3) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (rd_ptr >= wr_cnt) begin bad++; $display("FAIL trunc_missing actual=none required=%h", e); end
      else begin
        if (got_d[rd_ptr] !== e) begin bad++; $display("FAIL trunc_data actual=%h required=%h", got_d[rd_ptr], e); end
        rd_ptr++;
      end
    end
    total++; if (wr_cnt != rd_ptr) begin bad++; $display("FAIL trunc_extra actual=%0d required=%0d", wr_cnt, rd_ptr); end
    total++; if (trunc_cnt != tr + 1) begin bad++; $display("FAIL trunc_pulse actual=%0d required=1", trunc_cnt - tr); end
    total++; if (frame_cnt !== 3'd1) begin bad++; $display("FAIL trunc_frame_cnt actual=%0d required=1", frame_cnt); end
  endtask

  task automatic test_arst();
    logic [W:0] e;
    do_reset();
    push_frame(8'h2C, 1, 99);
    send(1'b0, 1, 1, 8'h2C, -1);
    push_frame(8'h30, 5, 2);
    send(1'b0, 1, 5, 8'h30, 2);
    #1 arst = 1'b1;
    #1;
    total++; if (s0_ready !== 1'b0)  begin bad++; $display("FAIL arst_s0_ready actual=%b required=0", s0_ready); end
    total++; if (fifo_w_en !== 1'b0) begin bad++; $display("FAIL arst_w_en actual=%b required=0", fifo_w_en); end
    total++; if (fifo_data !== '0)   begin bad++; $display("FAIL arst_data actual=%h required=0", fifo_data); end
    total++; if (frame_cnt !== '0)   begin bad++; $display("FAIL arst_frame_cnt actual=%0d required=0", frame_cnt); end
    set_src(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk); arst = 1'b0;
    @(posedge clk); #1;
    push_frame(8'h38, 4, 99);
    push_frame(8'hB8, 4, 99);
    fork
      send(1'b0, 1, 4, 8'h38, -1);
      send(1'b1, 1, 4, 8'hB8, -1);
    join
    repeat (2) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (rd_ptr >= wr_cnt) begin bad++; $display("FAIL arst_missing actual=none required=%h", e); end
      else begin
        if (got_d[rd_ptr] !== e) begin bad++; $display("FAIL arst_order actual=%h required=%h", got_d[rd_ptr], e); end
        rd_ptr++;
      end
    end
    total++; if (wr_cnt != rd_ptr) begin bad++; $display("FAIL arst_extra actual=%0d required=%0d", wr_cnt, rd_ptr); end
  endtask

  task automatic test_back_to_back();
    logic [W:0] e;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      push_frame(8'h40 + W'(f), 1, 99);
      if (f < 4) push_frame(8'hC0 + W'(f), 1, 99);
    end
    fork
      send(1'b0, 5, 1, 8'h40, -1);
      send(1'b1, 4, 1, 8'hC0, -1);
    join
    repeat (2) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (rd_ptr >= wr_cnt) begin bad++; $display("FAIL b2b_missing actual=none required=%h", e); end
      else begin
        if (got_d[rd_ptr] !== e) begin bad++; $display("FAIL b2b_order actual=%h required=%h", got_d[rd_ptr], e); end
        rd_ptr++;
      end
    end
    total++; if (wr_cnt != rd_ptr) begin bad++; $display("FAIL b2b_extra actual=%0d required=%0d", wr_cnt, rd_ptr); end
    total++; if (frame_cnt !== 3'd1) begin bad++; $display("FAIL b2b_wrap actual=%0d required=1", frame_cnt); end
    total++; if (nz_cnt != 0) begin bad++; $display("FAIL idle_data_zero actual=%0d required=0", nz_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_full();
    test_trunc();
    test_arst();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
